// File: rtl/tdr_echo_timer.sv
// TDR time-of-flight stage: counts fast-clock cycles from launch strobe to first qualified echo edge.
// Optional block averaging is built when TDR_ECHO_AVG_EN is defined.
module tdr_echo_timer #(
    parameter int CNT_W    = 16,
    parameter int BLANK    = 4,
    parameter int TIMEOUT  = 4000,
    parameter int AVG_LOG2 = 3
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             launch_i,
    input  logic             echo_i,
    output logic [CNT_W-1:0] result_o,
    output logic             result_valid_o,
    output logic             timeout_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] avg_o,
    output logic             avg_valid_o
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] BLANK_C   = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    if (BLANK >= TIMEOUT || 64'(TIMEOUT) >= (64'd1 << CNT_W) || AVG_LOG2 < 1) begin : g_bad_params
        $error("tdr_echo_timer: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             s1_q, s2_q, s3_q;
    logic             s1_d, s2_d, s3_d;
    logic             echo_edge;
    logic             take_result;

    assign s1_d      = echo_i;
    assign s2_d      = s1_q;
    assign s3_d      = s2_q;
    assign echo_edge = s2_q & ~s3_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_d      = 1'b0;
        overrun_d      = overrun_q;
        take_result    = 1'b0;
        if (state_q == IDLE) begin
            if (launch_i) begin
                cnt_d   = '0;
                state_d = MEASURE;
            end
        end else begin
            // A launch seen at any point of a measurement, completion cycle included, is lost.
            if (launch_i) begin
                overrun_d = 1'b1;
            end
            if (echo_edge && (cnt_q >= BLANK_C)) begin
                result_d       = cnt_q;
                result_valid_d = 1'b1;
                take_result    = 1'b1;
                state_d        = IDLE;
            end else if (cnt_q == TIMEOUT_C) begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            overrun_q      <= overrun_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = (state_q == MEASURE);
    assign overrun_o      = overrun_q;

`ifdef TDR_ECHO_AVG_EN
    localparam int ACC_W = CNT_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] n_q, n_d;
    logic                avg_pend_q, avg_pend_d;
    logic [CNT_W-1:0]    avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;

    // The block's last result is accumulated at its completion edge; the average follows one edge later.
    always_comb begin
        acc_d       = acc_q;
        n_d         = n_q;
        avg_pend_d  = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (avg_pend_q) begin
            avg_d       = CNT_W'(acc_q >> AVG_LOG2);
            avg_valid_d = 1'b1;
            acc_d       = '0;
            n_d         = '0;
        end else if (take_result) begin
            acc_d      = acc_q + ACC_W'(cnt_q);
            n_d        = n_q + 1'b1;
            avg_pend_d = (n_q == '1);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            acc_q       <= '0;
            n_q         <= '0;
            avg_pend_q  <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            n_q         <= n_d;
            avg_pend_q  <= avg_pend_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_o       = avg_q;
    assign avg_valid_o = avg_valid_q;
`else
    assign avg_o       = '0;
    assign avg_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_tdr_echo_timer.sv
// Directed self-checking bench for tdr_echo_timer; the averaging check runs when TDR_ECHO_AVG_EN is defined.
module tb_tdr_echo_timer;

    localparam int CNT_W    = 16;
    localparam int BLANK    = 4;
    localparam int TIMEOUT  = 4000;
    localparam int AVG_LOG2 = 2;

    logic             clk;
    logic             areset_n;
    logic             launch_i;
    logic             echo_i;
    logic [CNT_W-1:0] result_o;
    logic             result_valid_o;
    logic             timeout_o;
    logic             busy_o;
    logic             overrun_o;
    logic [CNT_W-1:0] avg_o;
    logic             avg_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    tdr_echo_timer #(
        .CNT_W   (CNT_W),
        .BLANK   (BLANK),
        .TIMEOUT (TIMEOUT),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk           (clk),
        .areset_n      (areset_n),
        .launch_i      (launch_i),
        .echo_i        (echo_i),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .timeout_o     (timeout_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .avg_o         (avg_o),
        .avg_valid_o   (avg_valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and land 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 unit after edge 0 (the launch sampling edge).
    task automatic fireLaunch();
        tick(3);
        launch_i = 1'b1;
        tick(1);
        launch_i = 1'b0;
    endtask

    // Echo rises before edge k; the result k+1 appears after edge k+2.
    task automatic applyStimulus(input int k, input string tag);
        fireLaunch();
        checkOutput({tag, "_busy_launch"}, 32'(busy_o), 32'd1);
        tick(k - 1);
        echo_i = 1'b1;
        tick(2);
        checkOutput({tag, "_valid_early"}, 32'(result_valid_o), 32'd0);
        checkOutput({tag, "_busy_pre"}, 32'(busy_o), 32'd1);
        tick(1);
        checkOutput({tag, "_valid"}, 32'(result_valid_o), 32'd1);
        checkOutput({tag, "_result"}, 32'(result_o), 32'(k + 1));
        checkOutput({tag, "_busy_done"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        tick(1);
        checkOutput({tag, "_valid_pulse"}, 32'(result_valid_o), 32'd0);
        echo_i = 1'b0;
    endtask

    // No qualified edge: timeout registers at edge TIMEOUT+1, result held.
    task automatic runTimeout(input logic early_echo, input logic [31:0] held, input string tag);
        fireLaunch();
        tick(1);
        if (early_echo) echo_i = 1'b1;
        tick(TIMEOUT - 1);
        checkOutput({tag, "_to_early"}, 32'(timeout_o), 32'd0);
        checkOutput({tag, "_busy_pre"}, 32'(busy_o), 32'd1);
        tick(1);
        checkOutput({tag, "_to"}, 32'(timeout_o), 32'd1);
        checkOutput({tag, "_busy_done"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_valid"}, 32'(result_valid_o), 32'd0);
        checkOutput({tag, "_held"}, 32'(result_o), held);
        tick(1);
        checkOutput({tag, "_to_pulse"}, 32'(timeout_o), 32'd0);
        echo_i = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_result"}, 32'(result_o), 32'd0);
        checkOutput({tag, "_valid"}, 32'(result_valid_o), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun_o), 32'd0);
        checkOutput({tag, "_avg"}, 32'(avg_o), 32'd0);
        checkOutput({tag, "_avg_valid"}, 32'(avg_valid_o), 32'd0);
    endtask

    initial begin
        areset_n = 1'b1;
        launch_i = 1'b0;
        echo_i   = 1'b0;
        #2 areset_n = 1'b0;
        #2;
        checkIdleZero("rst_hold");
        tick(3);
        areset_n = 1'b1;
        tick(2);
        checkIdleZero("rst_rel");

        $display("[TB] basic measurement");
        applyStimulus(10, "basic");

        $display("[TB] blanking");
        runTimeout(1'b1, 32'd11, "blank");

        $display("[TB] overrun");
        fireLaunch();
        tick(4);
        launch_i = 1'b1;
        tick(1);
        launch_i = 1'b0;
        checkOutput("ovr_flag", 32'(overrun_o), 32'd1);
        checkOutput("ovr_busy", 32'(busy_o), 32'd1);
        tick(4);
        echo_i = 1'b1;
        tick(2);
        checkOutput("ovr_valid_early", 32'(result_valid_o), 32'd0);
        tick(1);
        checkOutput("ovr_valid", 32'(result_valid_o), 32'd1);
        checkOutput("ovr_result", 32'(result_o), 32'd11);
        echo_i = 1'b0;
        tick(10);
        checkOutput("ovr_sticky", 32'(overrun_o), 32'd1);
        checkOutput("ovr_idle", 32'(busy_o), 32'd0);

        $display("[TB] reset mid-measurement");
        fireLaunch();
        tick(19);
        areset_n = 1'b0;
        #2;
        checkIdleZero("rst_mid");
        tick(1);
        areset_n = 1'b1;
        tick(1);
        checkOutput("rst_mid_busy", 32'(busy_o), 32'd0);
        applyStimulus(7, "after_rst");

`ifdef TDR_ECHO_AVG_EN
        $display("[TB] averaging");
        areset_n = 1'b0;
        tick(2);
        areset_n = 1'b1;
        applyStimulus(9, "avg1");
        checkOutput("avg1_avalid", 32'(avg_valid_o), 32'd0);
        applyStimulus(10, "avg2");
        checkOutput("avg2_avalid", 32'(avg_valid_o), 32'd0);
        runTimeout(1'b0, 32'd11, "avg_to");
        checkOutput("avg_to_avalid", 32'(avg_valid_o), 32'd0);
        applyStimulus(11, "avg3");
        checkOutput("avg3_avalid", 32'(avg_valid_o), 32'd0);
        applyStimulus(13, "avg4");
        checkOutput("avg4_avalid", 32'(avg_valid_o), 32'd1);
        checkOutput("avg4_avg", 32'(avg_o), 32'd11);
        tick(1);
        checkOutput("avg4_avalid_pulse", 32'(avg_valid_o), 32'd0);
        checkOutput("avg4_avg_held", 32'(avg_o), 32'd11);
`else
        $display("[TB] averaging disabled");
        applyStimulus(9, "noavg");
        checkOutput("noavg_avg", 32'(avg_o), 32'd0);
        checkOutput("noavg_avalid", 32'(avg_valid_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdr_echo_timer.md
# tdr_echo_timer

Time-of-flight measurement stage for the TDR path, running on the fast PLL clock directly downstream of the pulse generator. It consumes the one-cycle launch strobe that fires the output pulse, synchronises the reflection comparator input, and counts fast-clock cycles from launch to the first qualified rising edge of the echo. It reports each measurement or timeout as a one-cycle strobe, and can optionally produce a block average.

## Interface
- `CNT_W`, 16, width of the cycle counter and of `result_o`.
- `BLANK`, 4, count below which echo edges are ignored; masks the direct launch edge.
- `TIMEOUT`, 4000, count at which a measurement is abandoned; requires `BLANK < TIMEOUT < 2**CNT_W`.
- `AVG_LOG2`, 3, log2 of the number of results per average; used only with averaging.

Ports:
- `clk`, input, 1, fast clock.
- `areset_n`, input, 1, reset. One clock; reset is asynchronous and active-low.
- `launch_i`, input, 1, one-cycle launch strobe, synchronous to `clk`.
- `echo_i`, input, 1, raw comparator output; asynchronous.
- `result_o`, output, `CNT_W`, last measured count; held until the next valid result.
- `result_valid_o`, output, 1, one-cycle strobe marking a new `result_o`.
- `timeout_o`, output, 1, one-cycle strobe when a measurement times out.
- `busy_o`, output, 1, high while in MEASURE.
- `overrun_o`, output, 1, sticky flag: a launch was dropped.
- `avg_o`, output, `CNT_W`, block average.
- `avg_valid_o`, output, 1, one-cycle strobe marking a new `avg_o`.

## Operation
- Synchroniser: `echo_i` passes through flops s1 and s2, then a delay flop s3. The edge is `s2 & ~s3`. All three flops reset to 0.
- The state machine has two states, IDLE and MEASURE. It resets to IDLE.
- IDLE with `launch_i` = 1:
  - `cnt` <= 0.
  - State goes to MEASURE.
- MEASURE, evaluated each cycle in this priority order:
  1. Edge and `cnt >= BLANK`: `result_o` <= `cnt`, `result_valid_o` <= 1, state goes to IDLE.
  2. Otherwise, `cnt == TIMEOUT`: `timeout_o` <= 1, state goes to IDLE, `result_o` is unchanged.
  3. Otherwise, `cnt` <= `cnt + 1`.
- An edge wins over a timeout in the same cycle.
- Edges with `cnt < BLANK` are discarded, and no later re-arm happens for them. If `echo_i` is already high at launch, there is no edge, and the measurement times out.
- `launch_i` sampled while in MEASURE is dropped and sets `overrun_o`. This includes the completion cycle. `overrun_o` clears only on reset.
- Because the counter never exceeds `TIMEOUT`, no wrap is possible.
- `busy_o` is the registered state, equal to (state == MEASURE).
- Reset at any time, including mid-measurement, returns the block to IDLE with every output at 0, `cnt` = 0 and the accumulator cleared.

## Timing
- The launch is sampled at edge 0. `busy_o` is high from edge 0 until the completion edge.
- If `echo_i` is high before edge k (k ≥ 1) and was low before edge k−1, the qualified edge is visible after edge k+1. `result_o` = k+1, and `result_valid_o` is high for the cycle following edge k+2.
- With no echo, `timeout_o` pulses one cycle. It is registered at the edge where `cnt == TIMEOUT` is evaluated, which is `TIMEOUT`+1 edges after launch.
- A new launch is accepted from the first cycle after `busy_o` falls.
- `result_valid_o`, `timeout_o` and `avg_valid_o` are registered, are never high for more than one cycle, and are mutually exclusive with a launch acceptance in the same measurement.

## Configuration
- Macro: `TDR_ECHO_AVG_EN`.
- Defined:
  - A `CNT_W+AVG_LOG2`-bit accumulator adds each valid `result_o`. Timeouts are not added.
  - After 2**`AVG_LOG2` results, `avg_o` <= accumulated sum >> `AVG_LOG2` (truncating), including the current result.
  - `avg_valid_o` pulses in the cycle after the final `result_valid_o`. The accumulator and sample count then clear.
- Undefined:
  - No accumulator is built.
  - `avg_o` is tied to 0 and `avg_valid_o` is tied to 0.

## Test plan
- Reset defaults: hold `areset_n` low, then release with `echo_i` = 0. All outputs must be 0 and `busy_o` must be 0.
- Basic measurement: `BLANK`=4. Launch at edge 0, `echo_i` rises before edge 10. `result_o` = 11 with a one-cycle `result_valid_o`, `busy_o` drops, and `timeout_o` stays 0.
- Blanking: echo rises before edge 2 and stays high. The edge is ignored, `timeout_o` pulses at edge `TIMEOUT`+1, and `result_o` keeps its prior value.
- Overrun: a second `launch_i` at edge 5 of a measurement sets `overrun_o` = 1. The first measurement completes normally, and `overrun_o` stays 1 until reset.
- Reset mid-measurement: assert `areset_n` low at edge 20, then release. The block is in IDLE with `busy_o` = 0, and the next launch plus echo at edge 7 gives `result_o` = 8.
- With `TDR_ECHO_AVG_EN` and `AVG_LOG2`=2: results 10, 11, 12, 14, with one timeout interleaved, give `avg_o` = 11 and exactly one `avg_valid_o` after the fourth result.
